load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the data-memory/IO block. Converts CPU load/store requests (byte/half/word/dword, signed or unsigned) into the 64-bit doubleword bus that block expects: direccion, dataWrite, memWr in; dataRead out.
- Sub-doubleword stores to RAM are done as read-modify-write, because the memory only writes full 64-bit words.
- Loads are lane-extracted and then sign- or zero-extended.
- Simple valid/ready request interface; one-cycle response pulse.

Parameters:
- READ_WAIT, 1: cycles the address is held before dataRead is sampled; must be ≥1.
- IO_BIT, 12: address bit that selects the IO region (switches/LEDs); no RMW and no lane shifting are done there.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  load result, valid with resp_valid; 0 for stores
- resp_err  out  1  misaligned access, valid with resp_valid
- direccion  out  64  to memory/IO: {req_addr[63:3],3'b000}
- dataWrite  out  64  to memory/IO
- memWr  out  1  to memory/IO: write strobe
- dataRead  in  64  from memory/IO

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, direccion=0, dataWrite=0, memWr=0, state=IDLE.
- Reset asserted mid-operation: return to IDLE immediately; memWr drops asynchronously; the aborted request gets no response.
- Request latching: on accept, addr, size, wdata, write and unsigned are latched. lane = addr[2:0]. io = addr[IO_BIT].
- Misalignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- States: IDLE, RD, WR, RESP.
- Transitions out of IDLE on accept:
  - misaligned → RESP with err=1; no memory access.
  - load → RD.
  - store, dword or io → WR.
  - store, sub-dword, RAM → RD (read-modify-write).
- RD: direccion driven and memWr=0 for READ_WAIT cycles. dataRead is sampled at the last RD edge into rd_buf. Then go to WR if the access is a RMW store, else RESP.
- WR: exactly one cycle with memWr=1, direccion held. Then RESP.
  - dword or io: dataWrite = wdata.
  - sub-dword RAM store: dataWrite = rd_buf with bytes [lane .. lane+size_bytes-1] replaced by the low bytes of wdata.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Load data (RAM): take rd_buf >> (8*lane), keep 8/16/32/64 bits, then extend per req_unsigned.
- Load data (io): lane shift skipped; use rd_buf[7:0]/[15:0]/[31:0]/[63:0].
- Latency, with accept at edge T:
  - dword/io store: memWr during cycle T+1; resp_valid at T+2.
  - load: resp_valid at T+READ_WAIT+1.
  - RMW store: memWr at T+READ_WAIT+1; resp_valid at T+READ_WAIT+2.
  - misaligned: resp_valid at T+1.
- direccion, dataWrite and memWr are 0 in IDLE and RESP.
- A new request may be accepted in the cycle after RESP (req_ready high in IDLE). Back-to-back issue: one idle cycle minimum.

Optional Feature:
- Macro: LSU_PERF_EN.
- When defined: adds outputs perf_loads[31:0] and perf_stores[31:0].
  - Each increments on RESP of a non-error load/store.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. dword store: addr 0x10, wdata 0x1122334455667788 → memWr one cycle, direccion 0x10; then load dword 0x10 returns 0x1122334455667788 with resp_err=0.
2. byte store RMW: mem[0x10] = 0x1122334455667788; store byte 0xAB at 0x13 → dataWrite 0x11223344AB667788; signed byte load at 0x13 → 0xFFFFFFFFFFFFFFAB; unsigned → 0xAB.
3. misaligned: half load at 0x11 → resp_valid at T+1 with resp_err=1; memWr never asserted.
4. IO: sw=0x5A; word load at 0x1000 → resp_rdata 0x5A. Byte store 0x3C at 0x1000 → single WR with dataWrite[7:0]=0x3C and no RD phase.
5. reset asserted during the RD phase of an RMW store → memWr stays 0, no resp_valid, req_ready=1 after reset release.
6. READ_WAIT=2, signed word load at 0x14 of 0x80000000_00000000 → 0xFFFFFFFF80000000, resp_valid at T+3.

Source files
------------

// File: rtl/load_store_unit.sv
// Adapts CPU load/store requests to a 64-bit doubleword memory/IO bus; sub-doubleword RAM
// stores use read-modify-write. Define LSU_PERF_EN to add the perf_loads/perf_stores counters.
module load_store_unit #(
   parameter int READ_WAIT = 1,
   parameter int IO_BIT    = 12
) (
   input  logic        clk,
   input  logic        reset,
   // Handshake: a request transfers on a rising edge where req_valid && req_ready.
   // req_ready is high only in IDLE. resp_valid is a single-cycle pulse with no
   // back-pressure, and resp_rdata/resp_err are valid only while it is high.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] direccion,
   output logic [63:0] dataWrite,
   output logic        memWr,
   input  logic [63:0] dataRead,
   output logic [1:0]  state_dbg_o
`ifdef LSU_PERF_EN
   ,
   output logic [31:0] perf_loads,
   output logic [31:0] perf_stores
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

   localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [63:0]    addr_q, wdata_q, rd_buf_q;
   logic [1:0]     size_q;
   logic           write_q, uns_q, err_q;
   logic           mis_in, rd_last, io_q;
   logic [7:0]     size_mask, byte_en;
   logic [63:0]    wshift, merged, lane_data, load_val;

   assign io_q        = addr_q[IO_BIT];
   assign rd_last     = (cnt_q == CW'(READ_WAIT - 1));
   assign state_dbg_o = state_q;

   always_comb begin
      case (req_size)
         2'b01:   mis_in = req_addr[0];
         2'b10:   mis_in = |req_addr[1:0];
         2'b11:   mis_in = |req_addr[2:0];
         default: mis_in = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d = '0;
               if (mis_in)                                     state_d = RESP;
               else if (!req_write)                            state_d = RD;
               else if (req_size == 2'b11 || req_addr[IO_BIT]) state_d = WR;
               else                                            state_d = RD;
            end
         end
         RD: begin
            // Only RMW stores pass through RD with write_q set.
            if (rd_last) state_d = write_q ? WR : RESP;
            else         cnt_d   = cnt_q + 1'b1;
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_buf_q <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            err_q   <= mis_in;
         end
         if (state_q == RD && rd_last) rd_buf_q <= dataRead;
      end
   end

   always_comb begin
      case (size_q)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      byte_en = size_mask << addr_q[2:0];
      wshift  = wdata_q << {addr_q[2:0], 3'b000};
      merged  = '0;
      for (int i = 0; i < 8; i++)
         merged[8*i +: 8] = byte_en[i] ? wshift[8*i +: 8] : rd_buf_q[8*i +: 8];
   end

   // IO registers are not lane-addressed, so their data is taken unshifted.
   always_comb begin
      lane_data = io_q ? rd_buf_q : (rd_buf_q >> {addr_q[2:0], 3'b000});
      case (size_q)
         2'b00:   load_val = {{56{lane_data[7]  & ~uns_q}}, lane_data[7:0]};
         2'b01:   load_val = {{48{lane_data[15] & ~uns_q}}, lane_data[15:0]};
         2'b10:   load_val = {{32{lane_data[31] & ~uns_q}}, lane_data[31:0]};
         default: load_val = lane_data;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      resp_err   = (state_q == RESP) && err_q;
      resp_rdata = (state_q == RESP && !write_q && !err_q) ? load_val : 64'd0;
      memWr      = (state_q == WR);
      direccion  = (state_q == RD || state_q == WR) ? {addr_q[63:3], 3'b000} : 64'd0;
      dataWrite  = 64'd0;
      if (state_q == WR) dataWrite = (size_q == 2'b11 || io_q) ? wdata_q : merged;
   end

`ifdef LSU_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_loads  <= '0;
         perf_stores <= '0;
      end else if (state_q == RESP && !err_q) begin
         if (write_q && perf_stores != 32'hFFFF_FFFF)      perf_stores <= perf_stores + 1'b1;
         else if (!write_q && perf_loads != 32'hFFFF_FFFF) perf_loads  <= perf_loads + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-array model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid1 = 1'b0, req_valid2 = 1'b0;
  logic        req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        rdy1, rdy2, rv1, rv2, re1, re2, mw1, mw2;
  logic [63:0] rd1, rd2, dir1, dir2, dw1, dw2, dr1, dr2;
  logic [1:0]  st1, st2;
`ifdef LSU_PERF_EN
  logic [31:0] pl1, ps1, pl2, ps2;
`endif

  // bus-side memory/IO seen by both instances
  logic [63:0] bus_mem [0:15];
  logic [63:0] io_in = '0;
  logic [63:0] io_out = '0;
  int          wr_cnt = 0, resp_cnt = 0;
  logic [63:0] last_dir = '0, last_wd = '0;

  // reference model: byte-addressed RAM and IO registers
  logic [7:0]  ref_bytes [0:127];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.READ_WAIT(1), .IO_BIT(12)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(re1), .direccion(dir1), .dataWrite(dw1), .memWr(mw1), .dataRead(dr1),
    .state_dbg_o(st1)
`ifdef LSU_PERF_EN
    , .perf_loads(pl1), .perf_stores(ps1)
`endif
  );

  load_store_unit #(.READ_WAIT(2), .IO_BIT(12)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(rdy2),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv2), .resp_rdata(rd2),
    .resp_err(re2), .direccion(dir2), .dataWrite(dw2), .memWr(mw2), .dataRead(dr2),
    .state_dbg_o(st2)
`ifdef LSU_PERF_EN
    , .perf_loads(pl2), .perf_stores(ps2)
`endif
  );

  assign dr1 = dir1[12] ? io_in : bus_mem[dir1[6:3]];
  assign dr2 = dir2[12] ? io_in : bus_mem[dir2[6:3]];

  always @(posedge clk) begin
    if (mw1) begin
      wr_cnt++; last_dir = dir1; last_wd = dw1;
      if (dir1[12]) io_out <= dw1; else bus_mem[dir1[6:3]] <= dw1;
    end
    if (mw2) begin
      wr_cnt++; last_dir = dir2; last_wd = dw2;
      if (dir2[12]) io_out <= dw2; else bus_mem[dir2[6:3]] <= dw2;
    end
    if (rv1 || rv2) resp_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] v, input int n, input bit uns);
    logic [63:0] m;
    if (n == 8) return v;
    m = (64'h1 << (8 * n)) - 64'h1;
    v = v & m;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input bit uns);
    logic [63:0] v = '0;
    if (a[12]) v = io_in;
    else for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[int'(a[6:0]) + i];
    return ext(v, n, uns);
  endfunction

  function automatic logic [63:0] ref_dword(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[{a[6:3], 3'b000} + i];
    return v;
  endfunction

  task automatic do_req(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output bit er, output int lat, output int wrs);
    int w0;
    bit got;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    if (sel) req_valid2 = 1'b1; else req_valid1 = 1'b1;
    chk("req_ready", sel ? rdy2 : rdy1, 1);
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0; req_valid2 = 1'b0;
    lat = 0; rd = '0; er = 1'b0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? rv2 : rv1) begin
        got = 1'b1;
        rd  = sel ? rd2 : rd1;
        er  = sel ? re2 : re1;
      end
    end
    if (!got) lat = -1;
    wrs = wr_cnt - w0;
  endtask

  task automatic run_op(input string tag, input bit sel, input bit wr, input logic [1:0] sz,
                        input bit uns, input logic [63:0] a, input logic [63:0] wd);
    int n, rw, exp_lat, exp_wrs, lat, wrs;
    bit io, mis, er;
    logic [63:0] rd, exp_rd;
    n = 1 << sz; rw = sel ? 2 : 1; io = a[12];
    mis = (a % n) != 0;
    exp_rd = '0;
    if (mis) begin
      exp_lat = 1; exp_wrs = 0;
    end else if (!wr) begin
      exp_lat = rw + 1; exp_wrs = 0; exp_rd = ref_load(a, n, uns);
    end else begin
      exp_wrs = 1; exp_lat = (io || n == 8) ? 2 : rw + 2;
    end
    do_req(sel, wr, sz, uns, a, wd, rd, er, lat, wrs);
    chk({tag, "_err"}, er, mis);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_memwr"}, wrs, exp_wrs);
    if (wr && !mis) begin
      if (io) chk({tag, "_io"}, io_out, wd);
      else begin
        for (int i = 0; i < n; i++) ref_bytes[int'(a[6:0]) + i] = wd[8*i +: 8];
        chk({tag, "_mem"}, bus_mem[a[6:3]], ref_dword(a));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    logic [1:0]  sz;
    bit          wr, sel;
    int          w0, r0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy1, 1);
    chk("rst_resp_valid", rv1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_err", re1, 0);
    chk("rst_dir", dir1, 0);
    chk("rst_dw", dw1, 0);
    chk("rst_memwr", mw1, 0);
    reset = 1'b0;

    // preload RAM with full-dword stores
    for (int i = 0; i < 16; i++)
      run_op("preload", 1'b0, 1'b1, 2'b11, 1'b0, 64'(i * 8), {$urandom, $urandom});

    // dword store then load back
    run_op("t1_st", 1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788);
    chk("t1_dir", last_dir, 64'h10);
    run_op("t1_ld", 1'b0, 1'b0, 2'b11, 1'b0, 64'h10, '0);

    // byte RMW and signed/unsigned byte loads
    run_op("t2_st", 1'b0, 1'b1, 2'b00, 1'b0, 64'h13, 64'h00000000000000AB);
    chk("t2_dw", last_wd, 64'h11223344AB667788);
    run_op("t2_lds", 1'b0, 1'b0, 2'b00, 1'b0, 64'h13, '0);
    chk("t2_lds_val", ref_load(64'h13, 1, 1'b0), 64'hFFFFFFFFFFFFFFAB);
    run_op("t2_ldu", 1'b0, 1'b0, 2'b00, 1'b1, 64'h13, '0);

    // misaligned half load
    run_op("t3_mis", 1'b0, 1'b0, 2'b01, 1'b0, 64'h11, '0);

    // IO word load and byte store
    @(negedge clk) io_in = 64'h5A;
    run_op("t4_ld", 1'b0, 1'b0, 2'b10, 1'b0, 64'h1000, '0);
    run_op("t4_st", 1'b0, 1'b1, 2'b00, 1'b0, 64'h1000, 64'h3C);
    chk("t4_dw", last_wd[7:0], 8'h3C);

    // reset during the RD phase of an RMW store
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'h21; req_wdata = 64'hEE; req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    w0 = wr_cnt; r0 = resp_cnt;
    @(negedge clk) reset = 1'b1;
    #1;
    chk("t5_memwr", mw1, 0);
    chk("t5_resp", rv1, 0);
    chk("t5_ready", rdy1, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_wr", wr_cnt - w0, 0);
    chk("t5_no_resp", resp_cnt - r0, 0);
    chk("t5_ready_after", rdy1, 1);
    run_op("t5_ld", 1'b0, 1'b0, 2'b11, 1'b0, 64'h20, '0);

    // READ_WAIT=2 signed word load
    run_op("t6_st", 1'b1, 1'b1, 2'b11, 1'b0, 64'h10, 64'h8000000000000000);
    run_op("t6_ld", 1'b1, 1'b0, 2'b10, 1'b0, 64'h14, '0);
    chk("t6_val", ref_load(64'h14, 4, 1'b0), 64'hFFFFFFFF80000000);

    // random traffic on both instances
    for (int k = 0; k < 120; k++) begin
      sel = ($urandom_range(0, 3) == 0);
      wr  = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      wd  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        a = 64'h1000 + 64'($urandom_range(0, 15));
        @(negedge clk) io_in = {$urandom, $urandom};
      end else a = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 4) != 0) a = a & ~(64'(1 << sz) - 64'd1);
      run_op("rnd", sel, wr, sz, 1'($urandom_range(0, 1)), a, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
